// File: rtl/fetch_buffer_pkg.sv
// Shared encodings for the instruction-fetch buffer: control codes, bus widths, FSM states.
package fetch_buffer_pkg;

   localparam int unsigned AddrBus = 64;
   localparam int unsigned InstBus = 32;

   localparam logic [1:0] CTRL_STATE_Default = 2'd0;
   localparam logic [1:0] CTRL_STATE_Branch  = 2'd1;
   localparam logic [1:0] CTRL_STATE_Stalled = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_buffer_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs; flush empties it and wins over push/pop.
module fetch_fifo
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = AddrBus + InstBus
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             valid_q, valid_d;
   logic             pop_en;

   // Pointers rely on DEPTH being a power of two to wrap naturally.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pop_en   = pop_i && (count_q != '0);
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end
         if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         case ({push_i, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = valid_q;
   assign count_o = count_q;

   // Issue reserves a slot, so a push can never land on a full FIFO.
   assert property (@(posedge clk) disable iff (rst)
                    !(push_i && !flush_i && (count_q == CntW'(DEPTH))))
      else $error("fetch_fifo: push into full FIFO");

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: one outstanding I-cache request, {pc, inst} queue to decode, branch flush.
// Optional performance counters are enabled by defining FETCH_BUFFER_PERF_EN.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = AddrBus,
   parameter int unsigned INST_W = InstBus
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        ctrl_signal_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              icache_req_valid_o,
   input  logic              icache_req_ready_i,
   output logic [ADDR_W-1:0] icache_addr_o,
   input  logic              icache_resp_valid_i,
   input  logic [INST_W-1:0] icache_resp_data_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              fetch_busy_o
`ifdef FETCH_BUFFER_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt_o,
   output logic [31:0]       perf_drop_cnt_o
`endif
);

   localparam int unsigned EntW = ADDR_W + INST_W;
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              kill_q, kill_d;
   logic              req_valid_q, req_valid_d;
   logic              busy_q, busy_d;
   logic              branch, stalled, full, push;
   logic [EntW-1:0]   head;
   logic [CntW-1:0]   count;
   logic              fifo_valid;

   assign branch  = (ctrl_signal_i == CTRL_STATE_Branch);
   assign stalled = (ctrl_signal_i == CTRL_STATE_Stalled);
   assign full    = (count == CntW'(DEPTH));

   // A branch during REQ cannot retract the request, so it marks the response as stale.
   always_comb begin
      state_d  = state_q;
      req_pc_d = req_pc_q;
      kill_d   = kill_q;
      push     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!branch && !stalled && !full) begin
               state_d  = REQ;
               req_pc_d = pc_i;
            end
         end
         REQ: begin
            if (branch) begin
               kill_d = 1'b1;
            end
            if (icache_req_ready_i) begin
               state_d = (kill_q || branch) ? DROP : WAIT;
            end
         end
         WAIT: begin
            if (icache_resp_valid_i) begin
               push    = !branch;
               state_d = IDLE;
            end else if (branch) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (icache_resp_valid_i) begin
               kill_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      req_valid_d = (state_d == REQ);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         req_pc_q    <= '0;
         kill_q      <= 1'b0;
         req_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_pc_q    <= req_pc_d;
         kill_q      <= kill_d;
         req_valid_q <= req_valid_d;
         busy_q      <= busy_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EntW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  ({req_pc_q, icache_resp_data_i}),
      .pop_i   (inst_ready_i),
      .flush_i (branch),
      .head_o  (head),
      .valid_o (fifo_valid),
      .count_o (count)
   );

   assign icache_req_valid_o = req_valid_q;
   assign icache_addr_o      = req_pc_q;
   assign fetch_busy_o       = busy_q;
   assign inst_valid_o       = fifo_valid;
   assign inst_pc_o          = head[EntW-1:INST_W];
   assign inst_o             = head[INST_W-1:0];

`ifdef FETCH_BUFFER_PERF_EN
   logic        stall_evt, drop_evt;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;

   assign stall_evt = (state_q == IDLE) && (stalled || full);
   assign drop_evt  = icache_resp_valid_i &&
                      ((state_q == DROP) || ((state_q == WAIT) && branch));

   always_comb begin
      stall_cnt_d = stall_cnt_q + 32'(stall_evt);
      drop_cnt_d  = drop_cnt_q + 32'(drop_evt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign perf_stall_cnt_o = stall_cnt_q;
   assign perf_drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: queue-based reference model plus hand-computed pins.
module tb_fetch_buffer;

   localparam int unsigned DEPTH = 2;
   localparam logic [1:0] DEF = fetch_buffer_pkg::CTRL_STATE_Default;
   localparam logic [1:0] BR  = fetch_buffer_pkg::CTRL_STATE_Branch;
   localparam logic [1:0] ST  = fetch_buffer_pkg::CTRL_STATE_Stalled;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ctrl;
   logic [63:0] pc;
   logic        req_ready, resp_valid, inst_ready;
   logic [31:0] resp_data;
   logic        req_valid_o, inst_valid_o, busy_o;
   logic [63:0] addr_o, inst_pc_o;
   logic [31:0] inst_o;
`ifdef FETCH_BUFFER_PERF_EN
   logic [31:0] perf_stall_o, perf_drop_o;
`endif

   always #5 clk = ~clk;

   fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .INST_W(32)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .ctrl_signal_i       (ctrl),
      .pc_i                (pc),
      .icache_req_valid_o  (req_valid_o),
      .icache_req_ready_i  (req_ready),
      .icache_addr_o       (addr_o),
      .icache_resp_valid_i (resp_valid),
      .icache_resp_data_i  (resp_data),
      .inst_valid_o        (inst_valid_o),
      .inst_ready_i        (inst_ready),
      .inst_o              (inst_o),
      .inst_pc_o           (inst_pc_o),
      .fetch_busy_o        (busy_o)
`ifdef FETCH_BUFFER_PERF_EN
      ,
      .perf_stall_cnt_o    (perf_stall_o),
      .perf_drop_cnt_o     (perf_drop_o)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
   endtask

   // Instruction memory contents: 0x80000000 -> 0x13, 0x80000004 -> 0x17, 0x80001000 -> 0x1013.
   function automatic logic [31:0] inst_for(input logic [63:0] a);
      return a[31:0] ^ 32'h8000_0013;
   endfunction

   // I-cache stand-in state, only touched by the driver task.
   int          ready_hold = 0;
   int          resp_cd    = 0;
   int          resp_lat   = 1;
   bit          use_force  = 1'b0;
   logic [31:0] force_data = '0;
   logic [31:0] resp_pend  = '0;

   // Apply one cycle of inputs (decided at the falling edge) and return at the next falling edge.
   task automatic cyc(input logic [1:0] c, input logic [63:0] p, input logic rdy);
      ctrl       = c;
      pc         = p;
      inst_ready = rdy;
      resp_valid = 1'b0;
      resp_data  = '0;
      if (rst) resp_cd = 0;
      if (resp_cd == 1) begin
         resp_valid = 1'b1;
         resp_data  = resp_pend;
      end
      if (resp_cd > 0) resp_cd--;
      req_ready = (ready_hold == 0);
      if (req_valid_o && !rst) begin
         if (ready_hold > 0) ready_hold--;
         else begin
            resp_cd   = resp_lat;
            resp_pend = use_force ? force_data : inst_for(addr_o);
         end
      end
      @(negedge clk);
   endtask

   // Reference model: a queue of fetched pairs and flags for the single outstanding request.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   bit          m_req, m_wait, m_stale, m_clean;
   logic [63:0] m_addr;
   int unsigned m_stall, m_drop;

   always @(posedge clk) begin : model
      bit br, st, idle, pop, push, issue;
      br = (ctrl == BR);
      st = (ctrl == ST);
      if (rst) begin
         mq.delete();
         m_req = 0; m_wait = 0; m_stale = 0; m_clean = 1;
         m_addr = '0; m_stall = 0; m_drop = 0;
      end else begin
         idle  = !m_req && !m_wait;
         pop   = (mq.size() != 0) && inst_ready;
         push  = 0;
         issue = idle && !br && !st && (mq.size() < int'(DEPTH));
         if (idle && (st || mq.size() == int'(DEPTH))) m_stall++;
         if (m_req) begin
            if (br) m_stale = 1;
            if (req_ready) begin
               m_req  = 0;
               m_wait = 1;
            end
         end else if (m_wait) begin
            if (br) m_stale = 1;
            if (resp_valid) begin
               if (m_stale) m_drop++;
               else push = 1;
               m_wait  = 0;
               m_stale = 0;
            end
         end else if (issue) begin
            m_req  = 1;
            m_addr = pc;
         end
         if (br) mq.delete();
         else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
               mq.push_back({m_addr, resp_data});
               m_clean = 0;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      if (chk_en) begin
         chk("req_valid", 64'(req_valid_o), 64'(m_req));
         chk("req_addr", addr_o, m_addr);
         chk("busy", 64'(busy_o), 64'(m_req || m_wait));
         chk("inst_valid", 64'(inst_valid_o), 64'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("inst", 64'(inst_o), 64'(mq[0].inst));
            chk("inst_pc", inst_pc_o, mq[0].pc);
         end else if (m_clean) begin
            chk("inst_rst", 64'(inst_o), 64'h0);
            chk("inst_pc_rst", inst_pc_o, 64'h0);
         end
`ifdef FETCH_BUFFER_PERF_EN
         chk("perf_stall", 64'(perf_stall_o), 64'(m_stall));
         chk("perf_drop", 64'(perf_drop_o), 64'(m_drop));
`endif
      end
   end

   initial begin
      rst = 1'b1; ctrl = DEF; pc = '0; req_ready = 1'b0;
      resp_valid = 1'b0; resp_data = '0; inst_ready = 1'b0;
      cyc(DEF, 64'h0, 1'b0);
      cyc(DEF, 64'h0, 1'b0);
      chk_en = 1'b1;
      chk("rst_req_valid", 64'(req_valid_o), 64'h0);
      chk("rst_inst_valid", 64'(inst_valid_o), 64'h0);
      chk("rst_busy", 64'(busy_o), 64'h0);
      chk("rst_addr", addr_o, 64'h0);
      rst = 1'b0;

      // First fetch: issue, accept, respond one cycle later.
      cyc(DEF, 64'h8000_0000, 1'b0);
      chk("t1_req_valid", 64'(req_valid_o), 64'h1);
      chk("t1_addr", addr_o, 64'h8000_0000);
      cyc(DEF, 64'h8000_0004, 1'b0);
      cyc(DEF, 64'h8000_0004, 1'b0);
      chk("t1_inst_valid", 64'(inst_valid_o), 64'h1);
      chk("t1_inst", 64'(inst_o), 64'h13);
      chk("t1_inst_pc", inst_pc_o, 64'h8000_0000);

      // Decode blocked: queue fills to DEPTH and issue stops.
      for (int i = 0; i < 10; i++) cyc(DEF, 64'h8000_0004, 1'b0);
      chk("full_req_valid", 64'(req_valid_o), 64'h0);
      chk("full_busy", 64'(busy_o), 64'h0);
      chk("full_head_pc", inst_pc_o, 64'h8000_0000);
      cyc(ST, 64'h8000_0008, 1'b1);
      chk("drain_head_pc", inst_pc_o, 64'h8000_0004);
      chk("drain_head_inst", 64'(inst_o), 64'h17);
      cyc(ST, 64'h8000_0008, 1'b1);
      chk("drain_empty", 64'(inst_valid_o), 64'h0);
      for (int i = 0; i < 3; i++) cyc(ST, 64'h8000_0008, 1'b0);
      chk("stall_no_req", 64'(req_valid_o), 64'h0);

      // I-cache back-pressure: address held across 4 refused cycles.
      ready_hold = 4;
      cyc(DEF, 64'h8000_0004, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(ST, 64'h8000_0F00, 1'b0);
         chk("bp_req_valid", 64'(req_valid_o), 64'h1);
         chk("bp_addr", addr_o, 64'h8000_0004);
      end
      cyc(ST, 64'h8000_0F00, 1'b0);
      chk("bp_accepted", 64'(req_valid_o), 64'h0);
      cyc(ST, 64'h8000_0F00, 1'b0);
      chk("bp_inst", 64'(inst_o), 64'h17);

      // Branch while waiting; the late 0xDEADBEEF response must be dropped.
      resp_lat = 2; use_force = 1'b1; force_data = 32'hDEAD_BEEF;
      cyc(DEF, 64'h8000_0008, 1'b0);
      cyc(ST, 64'h8000_0008, 1'b0);
      cyc(BR, 64'h8000_1000, 1'b0);
      chk("br_flushed", 64'(inst_valid_o), 64'h0);
      chk("br_busy", 64'(busy_o), 64'h1);
      cyc(DEF, 64'h8000_1000, 1'b0);
      chk("br_dropped", 64'(inst_valid_o), 64'h0);
      resp_lat = 1; use_force = 1'b0;
      cyc(DEF, 64'h8000_1000, 1'b0);
      chk("br_new_addr", addr_o, 64'h8000_1000);
      cyc(DEF, 64'h8000_1000, 1'b0);
      cyc(DEF, 64'h8000_1000, 1'b0);
      chk("br_new_inst", 64'(inst_o), 64'h1013);

      // Branch colliding with a response and a pop, one entry queued.
      rst = 1'b1;
      cyc(DEF, 64'h8000_1000, 1'b0);
      rst = 1'b0;
      cyc(DEF, 64'h8000_1000, 1'b0);
      cyc(DEF, 64'h8000_1000, 1'b0);
      cyc(DEF, 64'h8000_1004, 1'b0);
      cyc(DEF, 64'h8000_1004, 1'b0);
      cyc(DEF, 64'h8000_1004, 1'b0);
      chk("col_one_queued", 64'(inst_valid_o), 64'h1);
      cyc(BR, 64'h8000_2000, 1'b1);
      chk("col_empty", 64'(inst_valid_o), 64'h0);
      chk("col_idle", 64'(busy_o), 64'h0);
`ifdef FETCH_BUFFER_PERF_EN
      chk("col_perf_drop", 64'(perf_drop_o), 64'h1);
`endif

      // Stalled for 5 cycles from IDLE.
      for (int i = 0; i < 5; i++) begin
         cyc(ST, 64'h8000_2000, 1'b0);
         chk("st5_no_req", 64'(req_valid_o), 64'h0);
      end
`ifdef FETCH_BUFFER_PERF_EN
      chk("st5_perf_stall", 64'(perf_stall_o), 64'h5);
`endif

      // Reset while a request is being presented and accepted.
      ready_hold = 1;
      cyc(DEF, 64'h8000_2000, 1'b0);
      cyc(DEF, 64'h8000_2000, 1'b0);
      chk("pre_rst_req", 64'(req_valid_o), 64'h1);
      rst = 1'b1;
      cyc(DEF, 64'h8000_2000, 1'b0);
      rst = 1'b0;
      chk("rst_req_req_valid", 64'(req_valid_o), 64'h0);
      chk("rst_req_addr", addr_o, 64'h0);
      chk("rst_req_busy", 64'(busy_o), 64'h0);
      chk("rst_req_inst_valid", 64'(inst_valid_o), 64'h0);
      chk("rst_req_inst", 64'(inst_o), 64'h0);
      chk("rst_req_inst_pc", inst_pc_o, 64'h0);

      // Mixed traffic, checked cycle by cycle against the model.
      for (int i = 0; i < 48; i++) begin
         logic [1:0] c;
         c = (i % 11 == 7) ? BR : ((i % 7 == 3) ? ST : DEF);
         resp_lat = (i % 2 == 0) ? 1 : 2;
         if (i % 13 == 5) ready_hold = 2;
         cyc(c, 64'h8000_3000 + 64'(4 * i), (i % 3) != 0);
      end
      for (int i = 0; i < 4; i++) cyc(ST, 64'h0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
